sram_bus_arbiter: RTL and testbench

- Shares one SRAM-like memory port (addr_ok/data_ok split handshake, in-order responses) between the instruction-fetch requester (pre-IF) and the data requester (EX/MEM).
- Tracks outstanding transactions in an ID FIFO and routes each data_ok back to its owner.
- Silently discards responses for instruction fetches cancelled by branch, exception, ertn or refetch flushes.
- Sits between the pipeline and the cache/AXI bridge.

---
 rtl/sram_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Shares one SRAM-like memory port (addr_ok/data_ok split handshake,
//   in-order responses) between the instruction-fetch requester and the
//   data requester. Every accepted transaction is recorded in an ID FIFO
//   as {owner, drop}. Each mem_data_ok is routed back to the owner of the
//   FIFO head. Fetch responses cancelled by a pipeline flush are discarded.
//
// Handshake: a requester raises *_req and holds it, with stable payload,
//   until it sees *_addr_ok. A request is accepted in the cycle where
//   req && addr_ok. mem_data_ok is a single-cycle response that pairs with
//   the oldest accepted, unanswered transaction. *_data_ok is a one-cycle
//   pulse in that same cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   inst_*              fetch requester (read-only, word size)
//   inst_cancel         flush: drop every outstanding fetch response
//   data_*              load/store requester
//   mem_*               downstream SRAM-like port (cache / AXI bridge)
//
// Parameter:
//   OUTSTANDING         ID FIFO depth (power of 2, >= 2)
//
// Optional build macro:
//   ARB_RR_EN           round-robin between the requesters using a 1-bit
//                       last_grant register. When undefined, data has
//                       fixed priority over inst.

module sram_bus_arbiter #(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_cancel,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(OUTSTANDING);

  // ID FIFO storage. owner: 0 = inst, 1 = data.
  logic [OUTSTANDING-1:0] owner_q;
  logic [OUTSTANDING-1:0] drop_q;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         count;

  // Lock: holds the grant while a request waits for mem_addr_ok.
  logic lock_q;
  logic lock_owner_q;

  logic grant_data;
  logic sel_req;
  logic full;
  logic push;
  logic pop;
  logic head_owner;
  logic head_drop;

`ifdef ARB_RR_EN
  // 0 = inst granted last, 1 = data granted last.
  logic last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b0;
    end else if (push) begin
      last_grant <= grant_data;
    end
  end
`endif

  // Grant selection. The lock overrides arbitration, so the request
  // presented downstream never changes before it is accepted.
  always_comb begin
    grant_data = 1'b0;
    if (lock_q) begin
      grant_data = lock_owner_q;
    end else if (data_req && inst_req) begin
`ifdef ARB_RR_EN
      grant_data = ~last_grant;
`else
      grant_data = 1'b1;
`endif
    end else begin
      grant_data = data_req;
    end
  end

  assign sel_req = grant_data ? data_req : inst_req;

  // Full is taken from the registered count only. A pop in the same cycle
  // does not re-open the port until the next cycle.
  assign full    = (count == FULL_CNT);
  assign mem_req = !reset && !full && sel_req;

  assign inst_addr_ok = mem_req && !grant_data && mem_addr_ok;
  assign data_addr_ok = mem_req &&  grant_data && mem_addr_ok;

  // An inst grant is always a word read with no write payload.
  assign mem_wr    = grant_data & data_wr;
  assign mem_size  = grant_data ? data_size  : 2'd2;
  assign mem_wstrb = grant_data ? data_wstrb : 4'd0;
  assign mem_addr  = grant_data ? data_addr  : inst_addr;
  assign mem_wdata = grant_data ? data_wdata : 32'd0;

  assign push = mem_req && mem_addr_ok;
  // A response with nothing outstanding is ignored.
  assign pop  = !reset && mem_data_ok && (count != '0);

  assign head_owner = owner_q[rd_ptr];
  assign head_drop  = drop_q[rd_ptr];

  assign inst_data_ok = pop && !head_owner && !head_drop;
  assign data_data_ok = pop &&  head_owner && !head_drop;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= '0;
      drop_q       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
    end else begin
      // Marking every inst slot is safe: stale slots are rewritten on push.
      if (inst_cancel) begin
        drop_q <= drop_q | ~owner_q;
      end
      // A fetch accepted in the cancel cycle is already stale.
      if (push) begin
        owner_q[wr_ptr] <= grant_data;
        drop_q[wr_ptr]  <= !grant_data && inst_cancel;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      lock_q       <= mem_req && !mem_addr_ok;
      lock_owner_q <= grant_data;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed testbench for sram_bus_arbiter. Stimulus drives the request side
// and the downstream responses. Each driven mem_data_ok pushes the expected
// routing {inst_data_ok, data_data_ok, rdata} into exp_q. A separate
// monitor pops and compares on every response cycle, and it flags stray
// data_ok pulses.

module tb_sram_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inst_cancel;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] exp_q[$];
  logic [33:0] exp_e;

  sram_bus_arbiter #(.OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    inst_req    = 1'b0;
    inst_addr   = 32'd0;
    inst_cancel = 1'b0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_wstrb  = 4'd0;
    data_addr   = 32'd0;
    data_wdata  = 32'd0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'd0;
  endtask

  // Drive one downstream response this cycle and record its expected routing.
  task automatic respond(input logic i_ok, input logic d_ok, input logic [31:0] rd);
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    exp_q.push_back({i_ok, d_ok, rd});
    next_cycle();
    mem_data_ok = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_data_ok) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL resp_unexpected: got mem_data_ok with no expectation queued, required none");
        end else begin
          exp_e = exp_q.pop_front();
          chk("resp_inst_data_ok", {31'd0, inst_data_ok}, {31'd0, exp_e[33]});
          chk("resp_data_data_ok", {31'd0, data_data_ok}, {31'd0, exp_e[32]});
          chk("resp_inst_rdata", inst_rdata, exp_e[31:0]);
          chk("resp_data_rdata", data_rdata, exp_e[31:0]);
        end
      end else if (inst_data_ok || data_data_ok) begin
        n_checks++;
        n_errors++;
        $display("FAIL stray_data_ok: got inst=%0b data=%0b expected 0 0", inst_data_ok, data_data_ok);
      end
    end
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    // Outputs are forced low during reset, even with live inputs.
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    at_neg();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("rst_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    next_cycle();

    // 1: single fetch, response two cycles later
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1;
    at_neg();
    chk("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h1c00_0000);
    chk("t1_mem_wr_size", {29'd0, mem_wr, mem_size}, 32'd2);
    chk("t1_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    next_cycle();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    next_cycle();
    respond(1'b1, 1'b0, 32'h0280_0000);

    // 2: conflict, data first then inst
    inst_req = 1'b1; inst_addr = 32'h1c00_0004;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hf;
    data_addr = 32'h0000_0100; data_wdata = 32'hdead_beef; mem_addr_ok = 1'b1;
    at_neg();
    chk("t2_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("t2_inst_addr_ok_blocked", {31'd0, inst_addr_ok}, 32'd0);
    chk("t2_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("t2_mem_wdata", mem_wdata, 32'hdead_beef);
    next_cycle();
    data_req = 1'b0;
    at_neg();
    chk("t2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t2_mem_addr_inst", mem_addr, 32'h1c00_0004);
    chk("t2_inst_payload", {mem_wr, mem_size, mem_wstrb, 25'd0}, {1'b0, 2'd2, 4'd0, 25'd0});
    chk("t2_inst_wdata", mem_wdata, 32'd0);
    next_cycle();
    inst_req = 1'b0; mem_addr_ok = 1'b0; data_wr = 1'b0;
    respond(1'b0, 1'b1, 32'h1111_0000);
    respond(1'b1, 1'b0, 32'h2222_0000);

    // 3a: data locked for 3 cycles while inst_req toggles
    data_req = 1'b1; data_addr = 32'h0000_0200; inst_addr = 32'h1c00_0008;
    for (int i = 0; i < 3; i++) begin
      inst_req = (i != 1);
      at_neg();
      chk("t3_mem_addr_locked", mem_addr, 32'h0000_0200);
      chk("t3_addr_ok_wait", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      next_cycle();
    end
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    at_neg();
    chk("t3_data_accept", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
    next_cycle();
    // 3b: inst locked, a later data request must not steal the port
    data_req = 1'b0; inst_addr = 32'h1c00_0100; mem_addr_ok = 1'b0;
    at_neg();
    chk("t3b_mem_addr_inst", mem_addr, 32'h1c00_0100);
    next_cycle();
    data_req = 1'b1; data_addr = 32'h0000_0400; mem_addr_ok = 1'b1;
    at_neg();
    chk("t3b_lock_mem_addr", mem_addr, 32'h1c00_0100);
    chk("t3b_lock_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    next_cycle();
    inst_req = 1'b0;
    at_neg();
    chk("t3b_data_after", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
    chk("t3b_mem_addr_data", mem_addr, 32'h0000_0400);
    next_cycle();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    respond(1'b0, 1'b1, 32'h3333_0000);
    respond(1'b1, 1'b0, 32'h4444_0000);
    respond(1'b0, 1'b1, 32'h5555_0000);

    // 4: two fetches, then cancel together with a new fetch, then a load
    inst_req = 1'b1; mem_addr_ok = 1'b1; inst_addr = 32'h1c00_0200;
    next_cycle();
    inst_addr = 32'h1c00_0204;
    next_cycle();
    inst_addr = 32'h1c00_0800; inst_cancel = 1'b1;
    at_neg();
    chk("t4_fetch_in_cancel", {31'd0, inst_addr_ok}, 32'd1);
    next_cycle();
    inst_cancel = 1'b0; inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h0000_0500;
    at_neg();
    chk("t4_load_accept", {31'd0, data_addr_ok}, 32'd1);
    next_cycle();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    respond(1'b0, 1'b0, 32'h6666_0001);
    respond(1'b0, 1'b0, 32'h6666_0002);
    respond(1'b0, 1'b0, 32'h6666_0003);
    respond(1'b0, 1'b1, 32'h6666_0004);

    // 5: fill the FIFO, then check the registered full behaviour
    data_req = 1'b1; mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_addr = 32'h0000_0300 + 32'(4 * i);
      at_neg();
      chk("t5_fill_accept", {31'd0, data_addr_ok}, 32'd1);
      next_cycle();
    end
    at_neg();
    chk("t5_full_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t5_full_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h7777_0001;
    exp_q.push_back({1'b0, 1'b1, 32'h7777_0001});
    at_neg();
    chk("t5_pop_cycle_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t5_pop_cycle_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    next_cycle();
    mem_data_ok = 1'b0;
    at_neg();
    chk("t5_resume_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t5_resume_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    next_cycle();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      respond(1'b0, 1'b1, 32'h7777_0010 + 32'(i));
    end

    // 6: reset with three fetches outstanding, then a spurious response
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_addr = 32'h1c00_0400 + 32'(4 * i);
      next_cycle();
    end
    reset = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h8888_0000;
    at_neg();
    chk("t6_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t6_rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    chk("t6_rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    next_cycle();
    reset = 1'b0; inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    respond(1'b0, 1'b0, 32'h8888_0001);
    data_req = 1'b1; data_addr = 32'h0000_0600; mem_addr_ok = 1'b1;
    at_neg();
    chk("t6_new_accept", {31'd0, data_addr_ok}, 32'd1);
    next_cycle();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    respond(1'b0, 1'b1, 32'h8888_0002);

    next_cycle();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
